deadtime_gate_driver: RTL and testbench

DEADTIME_GATE_DRIVER -- requirements
Module: deadtime_gate_driver

---
 rtl/deadtime_gate_driver.sv | 190 +++++++++++++++++++
 tb/tb_deadtime_gate_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deadtime_gate_driver.sv
// Three-phase gate driver: per-phase dead-time FSMs with registered gate outputs.
// Optional shoot-through fault latch enabled by defining SHOOT_THROUGH_FAULT_EN.
module deadtime_gate_driver #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic [2:0]          pwm_h_in,
    input  logic [2:0]          pwm_l_in,
    input  logic                fault_clr,
    output logic [2:0]          gate_h,
    output logic [2:0]          gate_l,
    output logic [2:0]          dt_active,
    output logic                fault
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_H_WAIT = 3'd1,
        ST_H_ON   = 3'd2,
        ST_L_WAIT = 3'd3,
        ST_L_ON   = 3'd4
    } state_e;

    localparam logic [DT_WIDTH-1:0] DT_ZERO = {DT_WIDTH{1'b0}};
    localparam logic [DT_WIDTH-1:0] DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    state_e              state_q [3];
    state_e              state_d [3];
    logic [DT_WIDTH-1:0] cnt_q   [3];
    logic [DT_WIDTH-1:0] cnt_d   [3];

    logic [2:0] req_h_s;
    logic [2:0] req_l_s;
    logic [2:0] overlap_s;
    logic       hold_off_s;
    logic       fault_q;
    logic       fault_d;
    logic [2:0] gate_h_q;
    logic [2:0] gate_h_d;
    logic [2:0] gate_l_q;
    logic [2:0] gate_l_d;
    logic [2:0] dt_active_q;
    logic [2:0] dt_active_d;

    // Request decode: simultaneous high and low requests count as no request.
    always_comb begin
        overlap_s = pwm_h_in & pwm_l_in;
        req_h_s   = pwm_h_in & ~pwm_l_in;
        req_l_s   = pwm_l_in & ~pwm_h_in;
    end

`ifdef SHOOT_THROUGH_FAULT_EN
    // Fault latch: overlap sets it and wins over a simultaneous clear.
    always_comb begin
        if (|overlap_s) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end
`else
    logic unused_fault_s;

    // Without the fault feature the latch is tied off and the clear is ignored.
    always_comb begin
        fault_d        = 1'b0;
        unused_fault_s = fault_clr | (|overlap_s);
    end
`endif

    // Disable or an active fault forces every phase to OFF at this edge.
    always_comb begin
        hold_off_s = ~enable | fault_d;
    end

    // Per-phase next-state and dead-time counter.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (hold_off_s) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = DT_ZERO;
            end else begin
                case (state_q[i])
                    ST_OFF: begin
                        if (req_h_s[i]) begin
                            if (dead_time == DT_ZERO) begin
                                state_d[i] = ST_H_ON;
                            end else begin
                                state_d[i] = ST_H_WAIT;
                                cnt_d[i]   = dead_time - DT_ONE;
                            end
                        end else if (req_l_s[i]) begin
                            if (dead_time == DT_ZERO) begin
                                state_d[i] = ST_L_ON;
                            end else begin
                                state_d[i] = ST_L_WAIT;
                                cnt_d[i]   = dead_time - DT_ONE;
                            end
                        end else begin
                            state_d[i] = ST_OFF;
                        end
                    end
                    ST_H_WAIT: begin
                        if (!req_h_s[i]) begin
                            state_d[i] = ST_OFF;
                            cnt_d[i]   = DT_ZERO;
                        end else if (cnt_q[i] == DT_ZERO) begin
                            state_d[i] = ST_H_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_ONE;
                        end
                    end
                    ST_H_ON: begin
                        if (!req_h_s[i]) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_H_ON;
                        end
                    end
                    ST_L_WAIT: begin
                        if (!req_l_s[i]) begin
                            state_d[i] = ST_OFF;
                            cnt_d[i]   = DT_ZERO;
                        end else if (cnt_q[i] == DT_ZERO) begin
                            state_d[i] = ST_L_ON;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_ONE;
                        end
                    end
                    ST_L_ON: begin
                        if (!req_l_s[i]) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_L_ON;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = DT_ZERO;
                    end
                endcase
            end
        end
    end

    // Output decode from the current state; a fault blanks the gates immediately.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            gate_h_d[i]    = (state_q[i] == ST_H_ON) & ~fault_d;
            gate_l_d[i]    = (state_q[i] == ST_L_ON) & ~fault_d;
            dt_active_d[i] = ((state_q[i] == ST_H_WAIT) | (state_q[i] == ST_L_WAIT)) & ~fault_d;
        end
    end

    // State, counter, fault and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= DT_ZERO;
            end
            fault_q     <= 1'b0;
            gate_h_q    <= 3'b000;
            gate_l_q    <= 3'b000;
            dt_active_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            fault_q     <= fault_d;
            gate_h_q    <= gate_h_d;
            gate_l_q    <= gate_l_d;
            dt_active_q <= dt_active_d;
        end
    end

    assign gate_h    = gate_h_q;
    assign gate_l    = gate_l_q;
    assign dt_active = dt_active_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Scoreboard bench for deadtime_gate_driver: directed stimulus queues expected
// output vectors tagged with an edge number; a monitor compares them at negedge.
module tb_deadtime_gate_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] dead_time = 8'd0;
    logic [2:0] pwm_h_in = 3'b000;
    logic [2:0] pwm_l_in = 3'b000;
    logic       fault_clr = 1'b0;
    logic [2:0] gate_h;
    logic [2:0] gate_l;
    logic [2:0] dt_active;
    logic       fault;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int         e;
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    deadtime_gate_driver #(.DT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .dead_time (dead_time),
        .pwm_h_in  (pwm_h_in),
        .pwm_l_in  (pwm_l_in),
        .fault_clr (fault_clr),
        .gate_h    (gate_h),
        .gate_l    (gate_l),
        .dt_active (dt_active),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: invariant check plus scoreboard pops for entries due at this edge.
    always @(negedge clk) begin
        checks++;
        if ((gate_h & gate_l) != 3'b000) begin
            failures++;
            $display("FAIL gate_overlap edge=%0d gate_h=%b gate_l=%b", edge_cnt, gate_h, gate_l);
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].e <= edge_cnt) begin
                checks++;
                if (sb[i].e < edge_cnt) begin
                    failures++;
                    $display("FAIL %s missed edge=%0d now=%0d", sb[i].name, sb[i].e, edge_cnt);
                end else if ({gate_h, gate_l, dt_active, fault} !== sb[i].v) begin
                    failures++;
                    $display("FAIL %s edge=%0d got gh=%b gl=%b dta=%b f=%b exp gh=%b gl=%b dta=%b f=%b",
                             sb[i].name, edge_cnt, gate_h, gate_l, dt_active, fault,
                             sb[i].v[9:7], sb[i].v[6:4], sb[i].v[3:1], sb[i].v[0]);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_range(input int a, input int b, input logic [2:0] gh, input logic [2:0] gl,
                             input logic [2:0] dta, input logic f, input string nm);
        for (int e = a; e <= b; e++) begin
            sb.push_back('{e, {gh, gl, dta, f}, nm});
        end
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic check_now(input string nm);
        checks++;
        if ({gate_h, gate_l, dt_active, fault} !== 10'd0) begin
            failures++;
            $display("FAIL %s got gh=%b gl=%b dta=%b f=%b exp all zero", nm, gate_h, gate_l, dt_active, fault);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout edge=%0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, p, q, r, s, a, e, b, rr;
        #1 check_now("reset_at_time0");
        repeat (3) @(negedge clk);
        check_now("reset_held");
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Turn-on with dead_time 5
        dead_time = 8'd5;
        pwm_h_in = 3'b001;
        n = edge_cnt + 1;
        exp_range(n, n, 3'b000, 3'b000, 3'b000, 1'b0, "s1_first_edge");
        exp_range(n + 1, n + 5, 3'b000, 3'b000, 3'b001, 1'b0, "s1_dead_time");
        exp_range(n + 6, n + 8, 3'b001, 3'b000, 3'b000, 1'b0, "s1_gate_on");
        wait_until(n + 8);

        // High-to-low changeover with dead_time 3, dead_time changed during WAIT
        dead_time = 8'd3;
        pwm_h_in = 3'b000;
        pwm_l_in = 3'b001;
        m = edge_cnt + 1;
        exp_range(m, m, 3'b001, 3'b000, 3'b000, 1'b0, "s2_h_still_on");
        exp_range(m + 1, m + 1, 3'b000, 3'b000, 3'b000, 1'b0, "s2_h_off");
        exp_range(m + 2, m + 4, 3'b000, 3'b000, 3'b001, 1'b0, "s2_dead_time");
        exp_range(m + 5, m + 7, 3'b000, 3'b001, 3'b000, 1'b0, "s2_l_on");
        wait_until(m + 1);
        dead_time = 8'd200;
        wait_until(m + 7);

        // Zero dead time, single-cycle low pulse on phase B
        dead_time = 8'd0;
        pwm_l_in = 3'b011;
        p = edge_cnt + 1;
        exp_range(p, p, 3'b000, 3'b001, 3'b000, 1'b0, "s3_pre");
        exp_range(p + 1, p + 1, 3'b000, 3'b011, 3'b000, 1'b0, "s3_pulse");
        exp_range(p + 2, p + 3, 3'b000, 3'b001, 3'b000, 1'b0, "s3_post");
        @(negedge clk);
        pwm_l_in = 3'b001;
        wait_until(p + 3);

        // Request withdrawn mid-wait on phase C with dead_time 8
        dead_time = 8'd8;
        pwm_h_in = 3'b100;
        q = edge_cnt + 1;
        exp_range(q, q, 3'b000, 3'b001, 3'b000, 1'b0, "s4_start");
        exp_range(q + 1, q + 4, 3'b000, 3'b001, 3'b100, 1'b0, "s4_wait");
        exp_range(q + 5, q + 12, 3'b000, 3'b001, 3'b000, 1'b0, "s4_abort");
        wait_until(q + 3);
        pwm_h_in = 3'b000;
        wait_until(q + 12);

`ifdef SHOOT_THROUGH_FAULT_EN
        // Shoot-through fault on phase C while A conducts high
        dead_time = 8'd0;
        pwm_l_in = 3'b000;
        pwm_h_in = 3'b001;
        r = edge_cnt + 1;
        exp_range(r, r, 3'b000, 3'b001, 3'b000, 1'b0, "f_l_still_on");
        exp_range(r + 1, r + 1, 3'b000, 3'b000, 3'b000, 1'b0, "f_gap");
        exp_range(r + 2, r + 2, 3'b001, 3'b000, 3'b000, 1'b0, "f_h_on");
        exp_range(r + 3, r + 4, 3'b000, 3'b000, 3'b000, 1'b1, "f_fault_set");
        exp_range(r + 5, r + 5, 3'b000, 3'b000, 3'b000, 1'b0, "f_fault_clear");
        exp_range(r + 6, r + 7, 3'b001, 3'b000, 3'b000, 1'b0, "f_recover");
        exp_range(r + 8, r + 8, 3'b001, 3'b000, 3'b000, 1'b0, "f_off_lag");
        exp_range(r + 9, r + 9, 3'b000, 3'b000, 3'b000, 1'b0, "f_off");
        wait_until(r + 2);
        pwm_h_in = 3'b101;
        pwm_l_in = 3'b100;
        fault_clr = 1'b1;
        wait_until(r + 4);
        pwm_h_in = 3'b001;
        pwm_l_in = 3'b000;
        wait_until(r + 5);
        fault_clr = 1'b0;
        wait_until(r + 7);
        pwm_h_in = 3'b000;
        wait_until(r + 9);
        s = r;
`else
        // Overlap on B is ignored, fault_clr has no effect
        pwm_h_in = 3'b010;
        pwm_l_in = 3'b011;
        fault_clr = 1'b1;
        r = edge_cnt + 1;
        exp_range(r, r + 3, 3'b000, 3'b001, 3'b000, 1'b0, "s5_overlap_b");
        wait_until(r + 3);
        // Overlap on A drops its own low request
        pwm_h_in = 3'b001;
        pwm_l_in = 3'b001;
        fault_clr = 1'b0;
        s = edge_cnt + 1;
        exp_range(s, s, 3'b000, 3'b001, 3'b000, 1'b0, "s5_a_lag");
        exp_range(s + 1, s + 3, 3'b000, 3'b000, 3'b000, 1'b0, "s5_a_off");
        wait_until(s + 1);
        pwm_h_in = 3'b000;
        pwm_l_in = 3'b000;
        wait_until(s + 3);
`endif

        // Enable drop forces OFF; re-enable restarts with the dead time
        dead_time = 8'd0;
        pwm_l_in = 3'b001;
        a = edge_cnt + 1;
        e = a + 2;
        exp_range(a, a, 3'b000, 3'b000, 3'b000, 1'b0, "s6_start");
        exp_range(a + 1, e, 3'b000, 3'b001, 3'b000, 1'b0, "s6_l_on");
        exp_range(e + 1, e + 2, 3'b000, 3'b000, 3'b000, 1'b0, "s6_disabled");
        exp_range(e + 3, e + 4, 3'b000, 3'b000, 3'b001, 1'b0, "s6_reenable_wait");
        exp_range(e + 5, e + 6, 3'b000, 3'b001, 3'b000, 1'b0, "s6_reenable_on");
        wait_until(a + 1);
        enable = 1'b0;
        wait_until(e);
        dead_time = 8'd2;
        wait_until(e + 1);
        enable = 1'b1;
        wait_until(e + 6);

        // Asynchronous reset with A in L_ON and B in H_WAIT
        dead_time = 8'd10;
        pwm_h_in = 3'b010;
        b = edge_cnt + 1;
        exp_range(b, b, 3'b000, 3'b001, 3'b000, 1'b0, "s7_pre");
        exp_range(b + 1, b + 3, 3'b000, 3'b001, 3'b010, 1'b0, "s7_wait");
        wait_until(b + 3);
        #2 rst = 1'b0;
        #1 check_now("async_reset_immediate");
        dead_time = 8'd0;
        pwm_h_in = 3'b001;
        pwm_l_in = 3'b000;
        @(negedge clk);
        check_now("reset_across_edge");
        rst = 1'b1;
        rr = edge_cnt + 1;
        exp_range(rr, rr, 3'b000, 3'b000, 3'b000, 1'b0, "s8_first_edge");
        exp_range(rr + 1, rr + 2, 3'b001, 3'b000, 3'b000, 1'b0, "s8_gate_on");
        wait_until(rr + 3);

        checks++;
        if (sb.size() != 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
